// File: rtl/logic_calc_unit.sv
// logic_calc_unit
//   Registered WIDTH-bit bitwise logic unit with an internal accumulator and
//   zero/parity flags. There is one result register, with valid/ready
//   handshakes on the input and output sides.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active-high
//     in_valid   operand/opcode presented by the source
//     in_ready   unit can accept this cycle (combinational, independent of in_valid)
//     a, b       WIDTH-bit operands
//     op         3-bit opcode
//                  000 AND   001 OR    010 NOT A    011 NOT B
//                  100 XOR   101 XNOR  110 ACC_OR   111 ACC_LOAD
//     out_valid  result register holds an unconsumed result
//     out_ready  sink accepts the result this cycle
//     result     registered result
//     zero       registered result == 0
//     parity     registered XOR-reduction of result
//     acc        current accumulator value
//
//   The first four opcodes match the legacy 1-bit calculator's encoding.
module logic_calc_unit #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic [WIDTH-1:0] acc
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             accept;
   logic [WIDTH-1:0] calc_res;

   // A full register can still take a new operand when the sink drains it in
   // the same cycle, which gives one result per cycle with no bubble.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      calc_res = '0;
      unique case (op)
         3'b000: calc_res = a & b;
         3'b001: calc_res = a | b;
         3'b010: calc_res = ~a;
         3'b011: calc_res = ~b;
         3'b100: calc_res = a ^ b;
         3'b101: calc_res = ~(a ^ b);
         3'b110: calc_res = acc_q | a;
         3'b111: calc_res = a;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      parity_d    = parity_q;
      acc_d       = acc_q;
      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = calc_res;
         zero_d      = (calc_res == '0);
         parity_d    = ^calc_res;
         // For both accumulator opcodes the new accumulator equals the result.
         if (op[2:1] == 2'b11) begin
            acc_d = calc_res;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         parity_q    <= 1'b0;
         acc_q       <= ACC_RESET;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         parity_q    <= parity_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_logic_calc_unit.sv
module tb_logic_calc_unit;

   localparam int         W     = 8;
   localparam logic [7:0] ACC_R = 8'h5A;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, result, acc;
   logic [2:0]   op;
   logic         zero, parity;

   logic         l_in_valid, l_in_ready, l_out_valid;
   logic [0:0]   l_a, l_b, l_result, l_acc;
   logic [2:0]   l_op;
   logic         l_zero, l_parity;

   int n_checks = 0;
   int n_err    = 0;

   logic         m_valid;
   logic [W-1:0] m_result, m_acc;

   logic [3:0]   leg_exp [4];

   logic_calc_unit #(.WIDTH(W), .ACC_RESET(ACC_R)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .parity(parity), .acc(acc)
   );

   logic_calc_unit #(.WIDTH(1), .ACC_RESET(1'b0)) dut_leg (
      .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .a(l_a), .b(l_b), .op(l_op), .out_valid(l_out_valid), .out_ready(1'b1),
      .result(l_result), .zero(l_zero), .parity(l_parity), .acc(l_acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] calc(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic [W-1:0] ac);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return ~x;
         3'd3:    return ~y;
         3'd4:    return x ^ y;
         3'd5:    return ~(x ^ y);
         3'd6:    return ac | x;
         default: return x;
      endcase
   endfunction

   // Transaction-level reference: one result slot, accumulator, handshake rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid  <= 1'b0;
         m_result <= '0;
         m_acc    <= ACC_R;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid  <= 1'b1;
         m_result <= calc(op, a, b, m_acc);
         if (op == 3'd6 || op == 3'd7) m_acc <= calc(op, a, b, m_acc);
      end else if (out_ready) begin
         m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
         check("cmp_out_valid", 64'(out_valid), 64'(m_valid));
         check("cmp_result", 64'(result), 64'(m_result));
         check("cmp_zero", 64'(zero), 64'(m_result == '0));
         check("cmp_parity", 64'(parity), 64'(^m_result));
         check("cmp_acc", 64'(acc), 64'(m_acc));
      end
   end

   task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xo);
      in_valid = v; a = xa; b = xb; op = xo;
   endtask

   // Present one op, let it be accepted, check the literal result after the edge.
   task automatic op_chk(input string name, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [2:0] xo, input logic [7:0] exp);
      drive(1'b1, xa, xb, xo);
      @(negedge clk);
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check(name, 64'(result), 64'(exp));
      #1;
   endtask

   initial begin
      leg_exp[0] = 4'b1000;
      leg_exp[1] = 4'b1110;
      leg_exp[2] = 4'b0011;
      leg_exp[3] = 4'b0101;

      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      l_in_valid = 1'b0; l_a = 1'b0; l_b = 1'b0; l_op = 3'd0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_parity", 64'(parity), 64'd0);
      check("rst_acc", 64'(acc), 64'h5A);
      @(negedge clk);
      #1 rst = 1'b0;

      // Legacy 1-bit truth table on the WIDTH=1 instance
      for (int i = 0; i < 16; i++) begin
         logic [3:0] row;
         logic [1:0] ab;
         ab = 2'(i >> 2);
         l_in_valid = 1'b1;
         l_a = ab[1];
         l_b = ab[0];
         l_op = {1'b0, 2'(i)};
         row = leg_exp[i & 3];
         @(negedge clk);
         check("legacy_valid", 64'(l_out_valid), 64'd1);
         check($sformatf("legacy_op%0d_a%0d_b%0d", i & 3, ab[1], ab[0]), 64'(l_result), 64'(row[ab]));
         #1;
      end
      l_in_valid = 1'b0;

      // Extended ops
      op_chk("and_a5_0f",  8'hA5, 8'h0F, 3'd0, 8'h05);
      check("and_zero", 64'(zero), 64'd0);
      op_chk("or_a5_0f",   8'hA5, 8'h0F, 3'd1, 8'hAF);
      op_chk("nota_a5",    8'hA5, 8'h0F, 3'd2, 8'h5A);
      op_chk("notb_0f",    8'hA5, 8'h0F, 3'd3, 8'hF0);
      op_chk("xor_a5_0f",  8'hA5, 8'h0F, 3'd4, 8'hAA);
      check("xor_parity", 64'(parity), 64'd0);
      check("xor_zero", 64'(zero), 64'd0);
      op_chk("xnor_a5_0f", 8'hA5, 8'h0F, 3'd5, 8'h55);
      op_chk("and_f0_0f",  8'hF0, 8'h0F, 3'd0, 8'h00);
      check("and_zero_set", 64'(zero), 64'd1);
      check("acc_untouched", 64'(acc), 64'h5A);

      // Accumulator
      op_chk("acc_load_01", 8'h01, 8'hEE, 3'd7, 8'h01);
      check("acc_after_load", 64'(acc), 64'h01);
      op_chk("acc_or_10", 8'h10, 8'hEE, 3'd6, 8'h11);
      op_chk("acc_or_80", 8'h80, 8'hEE, 3'd6, 8'h91);
      check("acc_or_parity", 64'(parity), 64'd1);
      op_chk("and_keeps_acc", 8'hFF, 8'h0F, 3'd0, 8'h0F);
      check("acc_hold_91", 64'(acc), 64'h91);

      // Backpressure
      op_chk("bp_first", 8'h3C, 8'h00, 3'd1, 8'h3C);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h11 * (i + 1)), 8'(8'h22 + i), 3'(6 + (i & 1)));
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_result_held", 64'(result), 64'h3C);
         check("bp_acc_held", 64'(acc), 64'h91);
         #1;
      end
      out_ready = 1'b1;
      op_chk("bp_release", 8'h12, 8'h34, 3'd4, 8'h26);

      // Back-to-back
      op_chk("b2b_0", 8'hFF, 8'h0F, 3'd0, 8'h0F);
      op_chk("b2b_1", 8'h30, 8'h03, 3'd1, 8'h33);
      op_chk("b2b_2", 8'h00, 8'hAA, 3'd3, 8'h55);
      op_chk("b2b_3", 8'hC3, 8'hC3, 3'd5, 8'hFF);

      // Async reset while stalled
      op_chk("load_ff", 8'hFF, 8'h00, 3'd7, 8'hFF);
      out_ready = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_result", 64'(result), 64'd0);
      check("arst_zero", 64'(zero), 64'd1);
      check("arst_acc", 64'(acc), 64'h5A);
      #1 rst = 1'b0;
      @(negedge clk);
      #1 out_ready = 1'b1;
      op_chk("post_rst_and", 8'h0F, 8'h33, 3'd0, 8'h03);
      op_chk("post_rst_acc_or", 8'h01, 8'h00, 3'd6, 8'h5B);

      // Random traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom));
         out_ready = 1'($urandom_range(0, 2) != 0);
         @(negedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
